sr_task_dispatcher: RTL
=======================

SR_TASK_DISPATCHER -- requirements
Module: sr_task_dispatcher

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: max cycles in OFFER awaiting cpu_ack (range 1..255).
REQ-002 Parameter SLICE_W, default 16: width of time-slice counter taken from head_info[SLICE_W-1:0].
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 head_tid  in  4  task ID at queue head cell (out_tid of head).
REQ-006 head_info  in  32  head cell scheduling info (info_out of head).
REQ-007 head_schden  in  1  head cell schedule-enable flag.
REQ-008 head_empty  in  1  head cell empty flag.
REQ-009 cpu_ack  in  1  CPU accepts offered task.
REQ-010 cpu_yield  in  1  running task gives up CPU voluntarily.
REQ-011 dispatch_valid  out  1  task offered to CPU.
REQ-012 dispatch_tid  out  4  offered/running task ID.
REQ-013 running  out  1  a dispatched task owns the CPU.
REQ-014 deq_req  out  1  one-cycle pulse, drives head cell dequeue.
REQ-015 preempt  out  1  one-cycle pulse, slice expired.
REQ-016 dispatch_count  out  16  accepted-dispatch count (only with SR_DISPATCH_STATS_EN).

Function
REQ-017 FSM states IDLE, OFFER, RUN, PREEMPT, one-hot or binary, never any other reachable state.
REQ-018 IDLE -> OFFER when head_schden=1 and head_empty=0; head_tid latched into dispatch_tid and head_info[SLICE_W-1:0] latched into slice register on that edge.
REQ-019 OFFER: dispatch_valid=1; timeout counter increments each cycle from 0.
REQ-020 OFFER -> RUN on cpu_ack=1; deq_req=1 for exactly the first RUN cycle; slice counter loaded from latched slice, value 0 replaced by 1.
REQ-021 OFFER -> IDLE without deq_req when head_empty=1 or head_schden=0 (withdrawal), or timeout counter equals ACK_TIMEOUT-1 with no ack; withdrawal and timeout lose to simultaneous cpu_ack.
REQ-022 RUN: running=1, dispatch_valid=0, slice counter decrements by 1 per cycle, no underflow.
REQ-023 RUN -> PREEMPT when slice counter is 1 on that edge (task ran exactly loaded-slice cycles).
REQ-024 RUN -> IDLE on cpu_yield=1, no preempt; yield coincident with expiry: yield wins, preempt stays 0.
REQ-025 PREEMPT: preempt=1, running=0 for one cycle, then IDLE unconditionally.
REQ-026 cpu_ack outside OFFER and cpu_yield outside RUN ignored.
REQ-027 dispatch_tid holds last latched value outside OFFER/RUN; input changes of head_tid/head_info after latch have no effect.
REQ-028 Minimum IDLE dwell one cycle between successive dispatches.

Reset
REQ-029 rst=1 at any edge, including mid-OFFER or mid-RUN: state IDLE, all outputs 0, dispatch_tid=0, counters 0; no deq_req or preempt pulse generated.
REQ-030 rst has priority over every other input.

Configuration
REQ-031 Macro SR_DISPATCH_STATS_EN defined: dispatch_count increments by 1 on each OFFER->RUN transition, wraps 16'hFFFF->0, reset 0.
REQ-032 Macro undefined: dispatch_count port and counter absent; all other behaviour identical.

Verification
REQ-033 Reset then head_schden=1, head_empty=0, head_tid=5, head_info=3, ack next cycle -> dispatch_valid 1 cycle, deq_req pulse, running 3 cycles, preempt pulse, back to IDLE.
REQ-034 Offer with no ack, ACK_TIMEOUT=15 -> dispatch_valid high exactly 15 cycles, return IDLE, deq_req never asserted.
REQ-035 Dispatch head_info=10, cpu_yield on 4th RUN cycle -> running falls next cycle, preempt never asserted.
REQ-036 head_info=0 -> slice treated as 1; head_info=2 with yield on 2nd RUN cycle -> yield wins, no preempt.
REQ-037 rst asserted in RUN cycle 2 -> next cycle all outputs 0, state IDLE, no preempt/deq_req pulse.
REQ-038 With SR_DISPATCH_STATS_EN, 3 acked dispatches plus 1 timed-out offer -> dispatch_count=3.

Source files
------------

// File: rtl/sr_task_dispatcher.sv
// Offers the ready-queue head task to the CPU, runs it for its time slice, then preempts or accepts a yield.
// Latency: offer 1 cycle after head becomes schedulable; deq_req in first RUN cycle; preempt after slice cycles.
// Backpressure: an offer waits up to ACK_TIMEOUT cycles for cpu_ack. SR_DISPATCH_STATS_EN adds dispatch_count.
module sr_task_dispatcher #(
    parameter int ACK_TIMEOUT = 15,
    parameter int SLICE_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  head_tid,
    input  logic [31:0] head_info,
    input  logic        head_schden,
    input  logic        head_empty,
    input  logic        cpu_ack,
    input  logic        cpu_yield,
    output logic        dispatch_valid,
    output logic [3:0]  dispatch_tid,
    output logic        running,
    output logic        deq_req,
    output logic        preempt
`ifdef SR_DISPATCH_STATS_EN
    ,
    output logic [15:0] dispatch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OFFER   = 2'd1,
        S_RUN     = 2'd2,
        S_PREEMPT = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 start_offer;
    logic                 accept;
    logic [7:0]           timeout_cnt;
    logic [SLICE_W-1:0]   slice_lat;
    logic [SLICE_W-1:0]   slice_cnt;
    logic [3:0]           tid_q;
    logic                 deq_q;

    // Only the low SLICE_W bits of head_info carry the slice.
    logic unused_info;
    assign unused_info = ^head_info;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_offer = 1'b0;
        accept      = 1'b0;
        case (state)
            S_IDLE: begin
                if (head_schden && !head_empty) begin
                    state_nxt   = S_OFFER;
                    start_offer = 1'b1;
                end
            end
            S_OFFER: begin
                // An ack in the same cycle beats both withdrawal and timeout.
                if (cpu_ack) begin
                    state_nxt = S_RUN;
                    accept    = 1'b1;
                end else if (head_empty || !head_schden || (timeout_cnt == TO_LAST)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (cpu_yield)                            state_nxt = S_IDLE;
                else if (slice_cnt == SLICE_W'(1))        state_nxt = S_PREEMPT;
            end
            S_PREEMPT: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt <= 8'd0;
            slice_lat   <= '0;
            slice_cnt   <= '0;
            tid_q       <= 4'd0;
            deq_q       <= 1'b0;
        end else begin
            deq_q <= accept;
            if (start_offer) begin
                tid_q       <= head_tid;
                slice_lat   <= head_info[SLICE_W-1:0];
                timeout_cnt <= 8'd0;
            end else if (state == S_OFFER) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
            // A zero slice still grants one cycle of CPU time.
            if (accept) begin
                slice_cnt <= (slice_lat == '0) ? SLICE_W'(1) : slice_lat;
            end else if ((state == S_RUN) && (slice_cnt != '0)) begin
                slice_cnt <= slice_cnt - SLICE_W'(1);
            end
        end
    end

`ifdef SR_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)         dispatch_count <= 16'd0;
        else if (accept) dispatch_count <= dispatch_count + 16'd1;
    end
`endif

    assign dispatch_valid = (state == S_OFFER);
    assign running        = (state == S_RUN);
    assign preempt        = (state == S_PREEMPT);
    assign deq_req        = deq_q;
    assign dispatch_tid   = tid_q;

endmodule
